// File: rtl/cpu16_pkg.sv
// rtl/cpu16_pkg.sv - shared constants, opcodes and state encoding for the cpu16 core
package cpu16_pkg;

  localparam int XLEN      = 16;
  localparam int NREG      = 4;
  localparam int MEM_DEPTH = 256;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_MUL   = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_LOAD  = 3'b100;
  localparam logic [2:0] OP_STORE = 3'b101;
  localparam logic [2:0] OP_NOP6  = 3'b110;
  localparam logic [2:0] OP_NOP7  = 3'b111;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB
  } state_t;

  // Sign-extend the 9-bit M-type immediate to a full data word.
  function automatic logic [XLEN-1:0] sext9(input logic [8:0] v);
    return {{(XLEN-9){v[8]}}, v};
  endfunction

endpackage

// File: rtl/cpu16_alu.sv
// rtl/cpu16_alu.sv - single-cycle add/sub, 16-step shift-add multiply, restoring floor divide (CPU16_DIV_EN)
module cpu16_alu
  import cpu16_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);

  // x: multiplicand (mul) or dividend/quotient shift register (div)
  // y: multiplier (mul) or divisor magnitude (div)
  // acc: partial product (mul) or partial remainder (div)
  logic            busy_q, busy_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] x_q, x_d;
  logic [XLEN-1:0] y_q, y_d;
  logic [XLEN-1:0] acc_q, acc_d;
`ifdef CPU16_DIV_EN
  logic            is_div_q, is_div_d;
  logic            neg_q, neg_d;
  logic            dz_q, dz_d;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;
  logic [XLEN-1:0] quot_fix;
`endif

  // Operation launch, one iteration per cycle while busy, and final result formation
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    x_d    = x_q;
    y_d    = y_q;
    acc_d  = acc_q;
    done   = 1'b0;
    result = '0;
`ifdef CPU16_DIV_EN
    is_div_d = is_div_q;
    neg_d    = neg_q;
    dz_d     = dz_q;
    shifted  = '0;
    diff     = '0;
    quot_fix = '0;
`endif
    if (!busy_q) begin
      if (start) begin
        case (op)
          OP_ADD: begin
            done   = 1'b1;
            result = a + b;
          end
          OP_SUB: begin
            done   = 1'b1;
            result = a - b;
          end
          OP_MUL: begin
            busy_d = 1'b1;
            cnt_d  = '0;
            x_d    = a;
            y_d    = b;
            acc_d  = '0;
`ifdef CPU16_DIV_EN
            is_div_d = 1'b0;
`endif
          end
`ifdef CPU16_DIV_EN
          OP_DIV: begin
            busy_d   = 1'b1;
            cnt_d    = '0;
            x_d      = a[XLEN-1] ? XLEN'(-a) : a;
            y_d      = b[XLEN-1] ? XLEN'(-b) : b;
            acc_d    = '0;
            is_div_d = 1'b1;
            neg_d    = a[XLEN-1] ^ b[XLEN-1];
            dz_d     = (b == '0);
          end
`endif
          default: begin
            done   = 1'b1;
            result = '0;
          end
        endcase
      end
    end else begin
      cnt_d = cnt_q + 4'd1;
`ifdef CPU16_DIV_EN
      if (is_div_q) begin
        // Restoring step: bring in the next dividend bit, subtract if it fits
        shifted = {acc_q, x_q[XLEN-1]};
        diff    = shifted - {1'b0, y_q};
        acc_d   = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
        x_d     = {x_q[XLEN-2:0], ~diff[XLEN]};
        // Magnitude quotient truncates; a non-zero remainder with mixed signs
        // needs one more step toward minus infinity.
        quot_fix = neg_q ? XLEN'(-x_d) : x_d;
        if (neg_q && (acc_d != '0)) begin
          quot_fix = quot_fix - XLEN'(1);
        end
        result = dz_q ? '1 : quot_fix;
      end else
`endif
      begin
        // Low 16 bits of a two's complement product do not depend on signedness
        acc_d  = acc_q + (y_q[0] ? x_q : '0);
        x_d    = {x_q[XLEN-2:0], 1'b0};
        y_d    = {1'b0, y_q[XLEN-1:1]};
        result = acc_d;
      end
      if (cnt_q == 4'd15) begin
        done   = 1'b1;
        busy_d = 1'b0;
      end
    end
  end

  // Iteration state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      x_q    <= '0;
      y_q    <= '0;
      acc_q  <= '0;
`ifdef CPU16_DIV_EN
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      dz_q     <= 1'b0;
`endif
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      x_q    <= x_d;
      y_q    <= y_d;
      acc_q  <= acc_d;
`ifdef CPU16_DIV_EN
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      dz_q     <= dz_d;
`endif
    end
  end

endmodule

// File: rtl/cpu16_top.sv
// rtl/cpu16_top.sv - multicycle 16-bit load/store core with inline memory and register file; CPU16_DIV_EN builds the divider
module cpu16_top
  import cpu16_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  output logic            ready_out,
  output logic [XLEN-1:0] pc_out
);

  logic [XLEN-1:0] memory_array [0:MEM_DEPTH-1];
  logic [XLEN-1:0] regs_q [0:NREG-1];

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] ir_q, ir_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] imm_q, imm_d;
  logic [XLEN-1:0] res_q, res_d;

  logic [2:0]      opcode;
  logic [1:0]      rd, rs1, rs2;
  logic            is_mem, is_store, is_nop;
  logic            retire, reg_we, mem_we, alu_start, alu_done;
  logic [2:0]      alu_op;
  logic [XLEN-1:0] alu_b, alu_result;

  assign opcode   = ir_q[15:13];
  assign rd       = ir_q[12:11];
  assign rs1      = ir_q[10:9];
  assign rs2      = ir_q[8:7];
  assign is_store = (opcode == OP_STORE);
  assign is_mem   = (opcode == OP_LOAD) || is_store;
`ifdef CPU16_DIV_EN
  assign is_nop   = (opcode == OP_NOP6) || (opcode == OP_NOP7);
`else
  assign is_nop   = (opcode == OP_NOP6) || (opcode == OP_NOP7) || (opcode == OP_DIV);
`endif

  // Loads and stores reuse the adder for base + immediate
  assign alu_op = is_mem ? OP_ADD : opcode;
  assign alu_b  = is_mem ? imm_q : b_q;

  cpu16_alu u_alu (
    .clk    (clk),
    .rst    (rst),
    .start  (alu_start),
    .op     (alu_op),
    .a      (a_q),
    .b      (alu_b),
    .done   (alu_done),
    .result (alu_result)
  );

  // Instruction sequencing: next state, datapath latches and retire strobes
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    imm_d     = imm_q;
    res_d     = res_q;
    alu_start = 1'b0;
    retire    = 1'b0;
    reg_we    = 1'b0;
    mem_we    = 1'b0;
    case (state_q)
      FETCH: begin
        ir_d    = memory_array[pc_q[7:0]];
        state_d = DECODE;
      end
      DECODE: begin
        a_d   = regs_q[rs1];
        b_d   = is_mem ? regs_q[rd] : regs_q[rs2];
        imm_d = sext9(ir_q[8:0]);
        if (is_nop) begin
          retire  = 1'b1;
          pc_d    = pc_q + XLEN'(1);
          state_d = FETCH;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        alu_start = 1'b1;
        if (alu_done) begin
          res_d   = alu_result;
          state_d = is_mem ? MEM : WB;
        end
      end
      MEM: begin
        if (is_store) begin
          mem_we  = 1'b1;
          retire  = 1'b1;
          pc_d    = pc_q + XLEN'(1);
          state_d = FETCH;
        end else begin
          res_d   = memory_array[res_q[7:0]];
          state_d = WB;
        end
      end
      WB: begin
        reg_we  = 1'b1;
        retire  = 1'b1;
        pc_d    = pc_q + XLEN'(1);
        state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  // Sequencer and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      imm_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      imm_q   <= imm_d;
      res_q   <= res_d;
    end
  end

  // Register file; reset wins over a pending writeback
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (reg_we) begin
      regs_q[rd] <= res_q;
    end
  end

  // Store port; contents survive reset, but a store caught by reset is dropped
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      memory_array[res_q[7:0]] <= b_q;
    end
  end

  assign ready_out = retire && !rst;
  assign pc_out    = pc_q;

endmodule

// File: tb/tb_cpu16_top.sv
// tb/tb_cpu16_top.sv - directed programs with a scoreboard of expected retire timing, PC, register and memory values
module tb_cpu16_top;
  import cpu16_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ready_out;
  logic [15:0] pc_out;

  cpu16_top dut (
    .clk       (clk),
    .rst       (rst),
    .ready_out (ready_out),
    .pc_out    (pc_out)
  );

  always #5 clk = ~clk;

`ifdef CPU16_DIV_EN
  localparam bit DIV_ON = 1'b1;
`else
  localparam bit DIV_ON = 1'b0;
`endif

  logic [15:0] exp_q[$];
  string       tag_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] pc_model;
  int          total_cyc;

  task automatic push(input string tag, input logic [15:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic pop_check(input logic [15:0] obs);
    logic [15:0] e;
    string       t;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %h required none", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s: observed %h required %h", t, obs, e);
      end
    end
  endtask

  task automatic chk_reg(input string tag, input int idx, input logic [15:0] v);
    push(tag, v);
    pop_check(dut.regs_q[idx]);
  endtask

  task automatic chk_mem(input string tag, input int addr, input logic [15:0] v);
    push(tag, v);
    pop_check(dut.memory_array[addr]);
  endtask

  function automatic logic [15:0] rt(input logic [2:0] op, input logic [1:0] rd,
                                     input logic [1:0] r1, input logic [1:0] r2);
    return {op, rd, r1, r2, 7'b0};
  endfunction

  function automatic logic [15:0] mt(input logic [2:0] op, input logic [1:0] rd,
                                     input logic [1:0] base, input logic [8:0] imm);
    return {op, rd, base, imm};
  endfunction

  function automatic logic [15:0] floor_div(input int a, input int b);
    int q;
    if (b == 0) return 16'hFFFF;
    q = a / b;
    if ((a % b != 0) && ((a < 0) != (b < 0))) q = q - 1;
    return 16'(q);
  endfunction

  // Hold reset and fill memory with NOPs so the program area is well defined
  task automatic begin_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 256; i++) dut.memory_array[i] = 16'hE000;
  endtask

  task automatic end_reset();
    @(negedge clk);
    rst       = 1'b0;
    pc_model  = 16'd0;
    total_cyc = 0;
  endtask

  // Run one instruction from inside its FETCH cycle; check retire, latency and new PC
  task automatic run_one(input string tag, input int exp_lat);
    int cyc = 0;
    bit got = 1'b0;
    while (!got && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (ready_out) got = 1'b1;
    end
    push({tag, "_retired"}, 16'd1);
    pop_check(16'(got));
    push({tag, "_cycles"}, 16'(exp_lat));
    pop_check(16'(cyc + 1));
    total_cyc += cyc + 1;
    @(posedge clk);
    #1;
    pc_model = pc_model + 16'd1;
    push({tag, "_pc"}, pc_model);
    pop_check(pc_out);
  endtask

  logic [15:0] prog   [0:10];
  int          lat    [0:10];
  int          rd_idx [0:10];
  logic [15:0] rd_val [0:10];
  int          dv_a   [0:3];
  int          dv_b   [0:3];

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    push("rst_pc", 16'd0);
    pop_check(pc_out);
    push("rst_ready", 16'd0);
    pop_check(16'(ready_out));
    for (int i = 0; i < 4; i++) chk_reg($sformatf("rst_x%0d", i), i, 16'd0);

    // Data-dependent program
    begin_reset();
    dut.memory_array[16] = 16'hFFFC;
    dut.memory_array[17] = 16'd6;
    dut.memory_array[18] = 16'd13;
    dut.memory_array[19] = 16'hFFF6;
    prog[0]  = mt(OP_LOAD, 0, 0, 9'd16);  lat[0]  = 5;  rd_idx[0]  = 0; rd_val[0]  = 16'hFFFC;
    prog[1]  = mt(OP_LOAD, 1, 3, 9'd17);  lat[1]  = 5;  rd_idx[1]  = 1; rd_val[1]  = 16'd6;
    prog[2]  = mt(OP_LOAD, 2, 3, 9'd18);  lat[2]  = 5;  rd_idx[2]  = 2; rd_val[2]  = 16'd13;
    prog[3]  = rt(OP_ADD, 3, 1, 0);       lat[3]  = 4;  rd_idx[3]  = 3; rd_val[3]  = 16'd2;
    prog[4]  = rt(OP_MUL, 2, 2, 0);       lat[4]  = 20; rd_idx[4]  = 2; rd_val[4]  = 16'hFFCC;
    prog[5]  = rt(OP_DIV, 0, 2, 1);       lat[5]  = DIV_ON ? 20 : 2;
    rd_idx[5] = 0; rd_val[5] = DIV_ON ? 16'hFFF7 : 16'hFFFC;
    prog[6]  = rt(OP_SUB, 1, 1, 0);       lat[6]  = 4;  rd_idx[6]  = 1;
    rd_val[6] = DIV_ON ? 16'd15 : 16'd10;
    prog[7]  = mt(OP_STORE, 2, 3, 9'd17); lat[7]  = 4;  rd_idx[7]  = 2; rd_val[7]  = 16'hFFCC;
    prog[8]  = rt(OP_ADD, 1, 1, 1);       lat[8]  = 4;  rd_idx[8]  = 1;
    rd_val[8] = DIV_ON ? 16'd30 : 16'd20;
    prog[9]  = rt(OP_MUL, 0, 3, 2);       lat[9]  = 20; rd_idx[9]  = 0; rd_val[9]  = 16'hFF98;
    prog[10] = mt(OP_STORE, 0, 3, 9'd15); lat[10] = 4;  rd_idx[10] = 0; rd_val[10] = 16'hFF98;
    for (int i = 0; i < 11; i++) dut.memory_array[i] = prog[i];
    end_reset();
    for (int i = 0; i < 11; i++) begin
      run_one($sformatf("prog%0d", i), lat[i]);
      chk_reg($sformatf("prog%0d_rd", i), rd_idx[i], rd_val[i]);
    end
    chk_mem("prog_mem19", 19, 16'hFFCC);
    chk_mem("prog_mem17", 17, 16'hFF98);
    chk_reg("prog_x3_final", 3, 16'd2);
    chk_reg("prog_x2_final", 2, 16'hFFCC);
    push("prog_within_150", 16'd1);
    pop_check(16'(total_cyc <= 150));

    // Divide edge cases (NOP when the divider is not built)
    dv_a[0] = 7;      dv_b[0] = -2;
    dv_a[1] = -8;     dv_b[1] = 2;
    dv_a[2] = 5;      dv_b[2] = 0;
    dv_a[3] = -32768; dv_b[3] = -1;
    for (int k = 0; k < 4; k++) begin
      begin_reset();
      dut.memory_array[32] = 16'(dv_a[k]);
      dut.memory_array[33] = 16'(dv_b[k]);
      dut.memory_array[0]  = mt(OP_LOAD, 0, 3, 9'd32);
      dut.memory_array[1]  = mt(OP_LOAD, 1, 3, 9'd33);
      dut.memory_array[2]  = rt(OP_DIV, 2, 0, 1);
      end_reset();
      run_one($sformatf("div%0d_ld0", k), 5);
      run_one($sformatf("div%0d_ld1", k), 5);
      run_one($sformatf("div%0d_op", k), DIV_ON ? 20 : 2);
      chk_reg($sformatf("div%0d_q", k), 2, DIV_ON ? floor_div(dv_a[k], dv_b[k]) : 16'd0);
    end

    // Reset in the middle of a multiply, then rerun the same program
    begin_reset();
    dut.memory_array[16] = 16'd5;
    dut.memory_array[17] = 16'd3;
    dut.memory_array[0]  = mt(OP_LOAD, 1, 0, 9'd16);
    dut.memory_array[1]  = mt(OP_LOAD, 2, 0, 9'd17);
    dut.memory_array[2]  = rt(OP_MUL, 1, 1, 2);
    end_reset();
    run_one("mr_ld0", 5);
    run_one("mr_ld1", 5);
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    push("mr_pc", 16'd0);
    pop_check(pc_out);
    push("mr_ready", 16'd0);
    pop_check(16'(ready_out));
    for (int i = 0; i < 4; i++) chk_reg($sformatf("mr_x%0d", i), i, 16'd0);
    chk_mem("mr_mem16", 16, 16'd5);
    end_reset();
    run_one("mr2_ld0", 5);
    run_one("mr2_ld1", 5);
    run_one("mr2_mul", 20);
    chk_reg("mr2_x1", 1, 16'd15);

    // Negative immediate wraps to address 0xFF; store/load round trip; opcode 111
    begin_reset();
    dut.memory_array[16] = 16'h1234;
    dut.memory_array[0]  = mt(OP_LOAD, 1, 0, 9'd16);
    dut.memory_array[1]  = mt(OP_STORE, 1, 0, 9'h1FF);
    dut.memory_array[2]  = mt(OP_LOAD, 2, 0, 9'h1FF);
    dut.memory_array[3]  = 16'hFFFF;
    end_reset();
    run_one("am_ld", 5);
    run_one("am_st", 4);
    chk_mem("am_mem255", 255, 16'h1234);
    run_one("am_ld_back", 5);
    chk_reg("am_x2", 2, 16'h1234);
    run_one("am_nop7", 2);
    chk_reg("am_nop_x0", 0, 16'd0);
    chk_reg("am_nop_x1", 1, 16'h1234);
    chk_reg("am_nop_x2", 2, 16'h1234);
    chk_reg("am_nop_x3", 3, 16'd0);
    chk_mem("am_nop_mem255", 255, 16'h1234);

    push("scoreboard_drained", 16'd0);
    pop_check(16'(exp_q.size() - 1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
